// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and constants common to uart_tx/uart_rx.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_MIN_CLKDIV = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for a single asynchronous input; STAGES must be at least 2.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 (LSB-first) serial receiver with mid-bit sampling, stop-bit check and break handling.
// Valid/ready does not apply: RX_DONE / RX_FERR are single-cycle strobes with no back-pressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int CLKDIV_W  = 16
) (
    input  logic                 CLK,
    input  logic                 SRST,
    input  logic [CLKDIV_W-1:0]  CLKDIV,
    input  logic                 RX_SERIAL,
    output logic [DATA_BITS-1:0] RX_DOUT,
    output logic                 RX_DONE,
    output logic                 RX_FERR,
    output logic                 RX_BUSY,
    output logic [2:0]           DBG_STATE
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    uart_rx_state_t        state_q, state_d;
    logic [CLKDIV_W-1:0]   cnt_q;
    logic [CLKDIV_W-1:0]   div_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_BITS-1:0]  shreg_q;
    logic [DATA_BITS-1:0]  dout_q;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q;
    logic                  rx_s;
    logic                  rx_d_q;
    logic [CLKDIV_W-1:0]   evt_n;
    logic                  evt;
    logic                  fall;

    uart_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (SRST),
        .d_i   (RX_SERIAL),
        .q_o   (rx_s)
    );

    // The start bit is checked half a period in, which centres every later sample.
    assign evt_n = (state_q == START) ? (div_q >> 1) : div_q;
    assign evt   = (cnt_q == evt_n);
    assign fall  = rx_d_q & ~rx_s;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (evt) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (evt && (bit_q == BIT_W'(DATA_BITS - 1))) state_d = STOP;
            end
            STOP: begin
                if (evt) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            rx_d_q  <= 1'b1;
        end else begin
            rx_d_q  <= rx_s;
            state_q <= state_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != IDLE);

            if ((state_d != state_q) || (state_q == IDLE) || (state_q == BREAK) || evt) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // The divisor is frozen per frame so a mid-frame CLKDIV write cannot skew sampling.
            if ((state_q == IDLE) && (state_d == START)) div_q <= CLKDIV;

            if ((state_q == START) && (state_d == DATA)) bit_q <= '0;

            if ((state_q == DATA) && evt) begin
                shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                bit_q   <= bit_q + 1'b1;
            end

            if (done_d) dout_q <= shreg_q;
        end
    end

    assign RX_DOUT   = dout_q;
    assign RX_DONE   = done_q;
    assign RX_FERR   = ferr_q;
    assign RX_BUSY   = busy_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural serial driver, frame scoreboard and latency model.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk;
    logic        SRST;
    logic [15:0] CLKDIV;
    logic        RX_SERIAL;
    logic [7:0]  RX_DOUT;
    logic        RX_DONE;
    logic        RX_FERR;
    logic        RX_BUSY;
    logic [2:0]  DBG_STATE;

    uart_rx #(.DATA_BITS(8), .CLKDIV_W(16)) dut (
        .CLK       (clk),
        .SRST      (SRST),
        .CLKDIV    (CLKDIV),
        .RX_SERIAL (RX_SERIAL),
        .RX_DOUT   (RX_DOUT),
        .RX_DONE   (RX_DONE),
        .RX_FERR   (RX_FERR),
        .RX_BUSY   (RX_BUSY),
        .DBG_STATE (DBG_STATE)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [7:0] exp_q[$];
    int         lat_q[$];
    int         start_q[$];
    logic [7:0] model_dout = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         ferr_seen = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] mon_e;
    int         mon_el;
    int         mon_s;
    int         mon_lat;

    always @(negedge clk) begin
        if (RX_DONE || RX_FERR) begin
            n_vec++;
            if (RX_DONE && RX_FERR) begin
                n_err++;
                $display("FAIL done_ferr_exclusive: done=%0b ferr=%0b, required not both", RX_DONE, RX_FERR);
            end
        end
        if (RX_DONE) begin
            done_seen++;
            n_vec++;
            if (prev_done) begin
                n_err++;
                $display("FAIL done_width: high two cycles at cycle %0d, required 1", cyc);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: dout=%02h at cycle %0d, required no frame", RX_DOUT, cyc);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_el  = lat_q.pop_front();
                mon_s   = start_q.pop_front();
                mon_lat = cyc - mon_s;
                if (RX_DOUT !== mon_e) begin
                    n_err++;
                    $display("FAIL rx_dout: got %02h, required %02h", RX_DOUT, mon_e);
                end
                n_vec++;
                if (mon_lat < mon_el - 1 || mon_lat > mon_el + 1) begin
                    n_err++;
                    $display("FAIL latency: got %0d, required %0d +/-1", mon_lat, mon_el);
                end
                model_dout = mon_e;
            end
        end
        if (RX_FERR) begin
            ferr_seen++;
            n_vec++;
            if (prev_ferr) begin
                n_err++;
                $display("FAIL ferr_width: high two cycles at cycle %0d, required 1", cyc);
            end
        end
        prev_done = RX_DONE;
        prev_ferr = RX_FERR;
    end

    // driver tasks; callers are positioned at a negedge
    task automatic send_frame(input logic [7:0] data, input logic stop, input int div, input int gap_bits);
        RX_SERIAL = 1'b0;
        if (stop) begin
            exp_q.push_back(data);
            lat_q.push_back(3 + div / 2 + 1 + 9 * (div + 1));
            start_q.push_back(cyc);
        end
        repeat (div + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_SERIAL = data[i];
            repeat (div + 1) @(negedge clk);
        end
        RX_SERIAL = stop;
        repeat (div + 1) @(negedge clk);
        if (stop) repeat (gap_bits * (div + 1)) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d frames pending, required 0", name, exp_q.size());
            exp_q.delete();
            lat_q.delete();
            start_q.delete();
        end
    endtask

    task automatic test_reset();
        SRST      = 1'b1;
        RX_SERIAL = 1'b1;
        CLKDIV    = 16'd15;
        repeat (4) @(negedge clk);
        SRST = 1'b0;
        model_dout = 8'h00;
        @(negedge clk);
        n_vec += 5;
        if (RX_DOUT !== 8'h00)  begin n_err++; $display("FAIL reset_dout: got %02h, required 00", RX_DOUT); end
        if (RX_DONE !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b, required 0", RX_DONE); end
        if (RX_FERR !== 1'b0)   begin n_err++; $display("FAIL reset_ferr: got %b, required 0", RX_FERR); end
        if (RX_BUSY !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b, required 0", RX_BUSY); end
        if (DBG_STATE !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", DBG_STATE, IDLE); end
    endtask

    task automatic test_loopback();
        int f0 = ferr_seen;
        int d0 = done_seen;
        CLKDIV = 16'd867;
        send_frame(8'hAB, 1'b1, 867, 2);
        send_frame(8'h0F, 1'b1, 867, 2);
        wait_drain(2000, "loopback");
        n_vec += 3;
        if (done_seen - d0 != 2) begin n_err++; $display("FAIL loopback_done_count: got %0d, required 2", done_seen - d0); end
        if (ferr_seen != f0)     begin n_err++; $display("FAIL loopback_ferr: got %0d, required 0", ferr_seen - f0); end
        if (RX_DOUT !== model_dout) begin n_err++; $display("FAIL loopback_hold: got %02h, required %02h", RX_DOUT, model_dout); end
    endtask

    task automatic test_glitch();
        int f0 = ferr_seen;
        int d0 = done_seen;
        CLKDIV = 16'd867;
        RX_SERIAL = 1'b0;
        repeat (100) @(negedge clk);
        n_vec++;
        if (RX_BUSY !== 1'b1) begin n_err++; $display("FAIL glitch_busy_high: got %b, required 1", RX_BUSY); end
        repeat (200) @(negedge clk);
        RX_SERIAL = 1'b1;
        repeat (600) @(negedge clk);
        n_vec += 4;
        if (done_seen != d0)    begin n_err++; $display("FAIL glitch_done: got %0d, required 0", done_seen - d0); end
        if (ferr_seen != f0)    begin n_err++; $display("FAIL glitch_ferr: got %0d, required 0", ferr_seen - f0); end
        if (RX_BUSY !== 1'b0)   begin n_err++; $display("FAIL glitch_busy_low: got %b, required 0", RX_BUSY); end
        if (DBG_STATE !== IDLE) begin n_err++; $display("FAIL glitch_state: got %0d, required %0d", DBG_STATE, IDLE); end
    endtask

    task automatic test_break();
        int f0 = ferr_seen;
        int d0 = done_seen;
        CLKDIV = 16'd15;
        send_frame(8'h55, 1'b0, 15, 0);
        repeat (20 * 16) @(negedge clk);
        n_vec += 4;
        if (RX_BUSY !== 1'b1)       begin n_err++; $display("FAIL break_busy_high: got %b, required 1", RX_BUSY); end
        if (ferr_seen - f0 != 1)    begin n_err++; $display("FAIL break_ferr_count: got %0d, required 1", ferr_seen - f0); end
        if (done_seen != d0)        begin n_err++; $display("FAIL break_done: got %0d, required 0", done_seen - d0); end
        if (RX_DOUT !== model_dout) begin n_err++; $display("FAIL break_dout: got %02h, required %02h", RX_DOUT, model_dout); end
        RX_SERIAL = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++;
        if (RX_BUSY !== 1'b0) begin n_err++; $display("FAIL break_busy_low: got %b, required 0", RX_BUSY); end
        repeat (32) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int f0 = ferr_seen;
        int d0 = done_seen;
        CLKDIV = 16'd15;
        send_frame(8'h00, 1'b1, 15, 0);
        send_frame(8'hFF, 1'b1, 15, 1);
        wait_drain(200, "b2b");
        n_vec += 2;
        if (done_seen - d0 != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d, required 2", done_seen - d0); end
        if (ferr_seen != f0)     begin n_err++; $display("FAIL b2b_ferr: got %0d, required 0", ferr_seen - f0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v = 8'hC3;
        int d0 = done_seen;
        int f0 = ferr_seen;
        CLKDIV = 16'd15;
        RX_SERIAL = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_SERIAL = v[i];
            repeat (16) @(negedge clk);
        end
        RX_SERIAL = v[4];
        repeat (8) @(negedge clk);
        SRST = 1'b1;
        RX_SERIAL = 1'b1;
        model_dout = 8'h00;
        @(negedge clk);
        SRST = 1'b0;
        repeat (200) @(negedge clk);
        n_vec += 5;
        if (done_seen != d0)    begin n_err++; $display("FAIL srst_done: got %0d, required 0", done_seen - d0); end
        if (ferr_seen != f0)    begin n_err++; $display("FAIL srst_ferr: got %0d, required 0", ferr_seen - f0); end
        if (RX_DOUT !== 8'h00)  begin n_err++; $display("FAIL srst_dout: got %02h, required 00", RX_DOUT); end
        if (RX_BUSY !== 1'b0)   begin n_err++; $display("FAIL srst_busy: got %b, required 0", RX_BUSY); end
        if (DBG_STATE !== IDLE) begin n_err++; $display("FAIL srst_state: got %0d, required %0d", DBG_STATE, IDLE); end
        send_frame(8'h3C, 1'b1, 15, 2);
        wait_drain(200, "srst_next");
    endtask

    task automatic test_clkdiv_change();
        int d0 = done_seen;
        CLKDIV = 16'd867;
        fork
            send_frame(8'hA5, 1'b1, 867, 1);
            begin
                repeat (3000) @(negedge clk);
                CLKDIV = 16'd433;
            end
        join
        send_frame(8'h5A, 1'b1, 433, 1);
        wait_drain(1000, "clkdiv");
        n_vec++;
        if (done_seen - d0 != 2) begin n_err++; $display("FAIL clkdiv_done_count: got %0d, required 2", done_seen - d0); end
    endtask

    task automatic test_random();
        int f0 = ferr_seen;
        int d0 = done_seen;
        int exp_ferr = 0;
        int exp_done = 0;
        int div;
        logic [7:0] b;
        for (int k = 0; k < 16; k++) begin
            div = $urandom_range(7, 40);
            b = 8'($urandom_range(0, 255));
            CLKDIV = 16'(div);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, 1'b0, div, 0);
                repeat (2 * (div + 1)) @(negedge clk);
                RX_SERIAL = 1'b1;
                repeat (2 * (div + 1)) @(negedge clk);
                exp_ferr++;
            end else begin
                send_frame(b, 1'b1, div, $urandom_range(0, 2));
                exp_done++;
            end
        end
        wait_drain(500, "random");
        n_vec += 3;
        if (done_seen - d0 != exp_done) begin n_err++; $display("FAIL random_done_count: got %0d, required %0d", done_seen - d0, exp_done); end
        if (ferr_seen - f0 != exp_ferr) begin n_err++; $display("FAIL random_ferr_count: got %0d, required %0d", ferr_seen - f0, exp_ferr); end
        if (RX_DOUT !== model_dout)     begin n_err++; $display("FAIL random_hold: got %02h, required %02h", RX_DOUT, model_dout); end
    endtask

    initial begin
        SRST      = 1'b1;
        RX_SERIAL = 1'b1;
        CLKDIV    = 16'd15;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv_change();
        test_random();
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
